// File: rtl/rf_preadd_pkg.sv
// Shared types and defaults for the symmetric-tap pre-add sequencer.
package rf_preadd_pkg;

  localparam int DATA_W_DEF  = 30;
  localparam int RF_SIZE_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int n_out(input int rf_size);
    return (rf_size + 1) / 2;
  endfunction

endpackage

// File: rtl/rf_preadd_out_reg.sv
// Single-entry output register with valid/ready handshake for the pre-adder stream.
module rf_preadd_out_reg
  import rf_preadd_pkg::*;
#(
  parameter int SUM_W  = DATA_W_DEF + 1,
  parameter int ADDR_W = $clog2(RF_SIZE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [SUM_W-1:0]  data_i,
  input  logic [ADDR_W-1:0] tap_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              load_ok_o,
  output logic              valid_o,
  output logic [SUM_W-1:0]  data_o,
  output logic [ADDR_W-1:0] tap_o,
  output logic              last_o
);

  logic              valid_q;
  logic [SUM_W-1:0]  data_q;
  logic [ADDR_W-1:0] tap_q;
  logic              last_q;

  // A new word may enter when the slot is empty or is being drained this cycle.
  assign load_ok_o = ~valid_q | ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tap_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      tap_q   <= tap_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tap_o   = tap_q;
  assign last_o  = last_q;

endmodule

// File: rtl/rf_symm_preadd_seq.sv
// Walks symmetric tap pairs (k, RF_SIZE-1-k) of the register file and streams their pre-added sums.
// Optional RF_PREADD_SUB_EN adds a 'sub' input selecting pre-subtraction for antisymmetric filters.
module rf_symm_preadd_seq
  import rf_preadd_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RF_SIZE = RF_SIZE_DEF,
  parameter int ADDR_W  = $clog2(RF_SIZE),
  parameter int SUM_W   = DATA_W + 1,
  parameter int N_OUT   = n_out(RF_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RF_PREADD_SUB_EN
  input  logic              sub,
`endif
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr_0,
  output logic [ADDR_W-1:0] rf_addr_1,
  input  logic [DATA_W-1:0] rf_data_0,
  input  logic [DATA_W-1:0] rf_data_1,
  output logic [SUM_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_tap,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(RF_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] CENTRE_K = ADDR_W'((RF_SIZE - 1) / 2);
  localparam bit                ODD      = (RF_SIZE % 2) == 1;

  state_e                    state_q;
  logic [ADDR_W-1:0]         k_q;
  logic                      sub_q;
  logic                      load_ok;
  logic                      capture;
  logic                      centre;
  logic signed [DATA_W-1:0]  d0;
  logic signed [DATA_W-1:0]  d1;
  logic signed [SUM_W-1:0]   data_d;

  // Centre tap of an odd-length file reads the same word on both ports; count it once.
  function automatic logic signed [SUM_W-1:0] preadd(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     do_sub,
    input logic                     is_centre
  );
    logic signed [SUM_W-1:0] sa;
    logic signed [SUM_W-1:0] sb;
    sa = {a[DATA_W-1], a};
    sb = {b[DATA_W-1], b};
    if (is_centre) return do_sub ? '0 : sa;
    return do_sub ? (sa - sb) : (sa + sb);
  endfunction

  assign rf_addr_0 = k_q;
  assign rf_addr_1 = TOP_ADDR - k_q;
  assign d0        = rf_data_0;
  assign d1        = rf_data_1;
  assign centre    = ODD && (k_q == CENTRE_K);
  assign data_d    = preadd(d0, d1, sub_q, centre);
  assign busy      = (state_q == RUN) | out_valid;
  assign capture   = (state_q == RUN) & load_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !busy) begin
            state_q <= RUN;
            k_q     <= '0;
          end
        end
        RUN: begin
          if (capture) begin
            if (k_q == LAST_K) begin
              state_q <= IDLE;
              k_q     <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef RF_PREADD_SUB_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if ((state_q == IDLE) && start && !busy) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  rf_preadd_out_reg #(
    .SUM_W  (SUM_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (capture),
    .data_i    (data_d),
    .tap_i     (k_q),
    .last_i    (k_q == LAST_K),
    .ready_i   (out_ready),
    .load_ok_o (load_ok),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .tap_o     (out_tap),
    .last_o    (out_last)
  );

endmodule

// File: tb/tb_rf_symm_preadd_seq.sv
// Bench for rf_symm_preadd_seq: an 8-deep and a 7-deep instance driven from behavioural register files.
module tb_rf_symm_preadd_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ready;
  logic sel;
`ifdef RF_PREADD_SUB_EN
  logic sub;
`endif
  bit   sub_cur;

  logic signed [29:0] rfA [8];
  logic signed [29:0] rfB [8];

  logic [2:0]  addrA0, addrA1, addrB0, addrB1, tapA, tapB;
  logic [29:0] dA0, dA1, dB0, dB1;
  logic [30:0] dataA, dataB;
  logic        lastA, lastB, validA, validB, busyA, busyB;
  logic        startA, startB;

  logic [30:0] c_data;
  logic [2:0]  c_tap, c_addr0;
  logic        c_last, c_valid, c_busy;

  int n_tests = 0;
  int n_fail  = 0;
  longint exp_v [4];

  always #5 clk = ~clk;

  assign dA0 = rfA[addrA0];
  assign dA1 = rfA[addrA1];
  assign dB0 = rfB[addrB0];
  assign dB1 = rfB[addrB1];
  assign startA = start & ~sel;
  assign startB = start & sel;

  assign c_data  = sel ? dataB  : dataA;
  assign c_tap   = sel ? tapB   : tapA;
  assign c_addr0 = sel ? addrB0 : addrA0;
  assign c_last  = sel ? lastB  : lastA;
  assign c_valid = sel ? validB : validA;
  assign c_busy  = sel ? busyB  : busyA;

  rf_symm_preadd_seq dutA (
    .clk(clk), .rst_n(rst_n),
`ifdef RF_PREADD_SUB_EN
    .sub(sub),
`endif
    .start(startA), .busy(busyA),
    .rf_addr_0(addrA0), .rf_addr_1(addrA1),
    .rf_data_0(dA0), .rf_data_1(dA1),
    .out_data(dataA), .out_tap(tapA), .out_last(lastA),
    .out_valid(validA), .out_ready(ready)
  );

  rf_symm_preadd_seq #(.RF_SIZE(7)) dutB (
    .clk(clk), .rst_n(rst_n),
`ifdef RF_PREADD_SUB_EN
    .sub(sub),
`endif
    .start(startB), .busy(busyB),
    .rf_addr_0(addrB0), .rf_addr_1(addrB1),
    .rf_data_0(dB0), .rf_data_1(dB1),
    .out_data(dataB), .out_tap(tapB), .out_last(lastB),
    .out_valid(validB), .out_ready(ready)
  );

  typedef struct packed {
    logic [7:0][31:0] vals;
    logic [3:0][31:0] exps;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int v0, v1, v2, v3, v4, v5, v6, v7,
                              input int e0, e1, e2, e3);
    vec_t r;
    r.vals[0] = v0; r.vals[1] = v1; r.vals[2] = v2; r.vals[3] = v3;
    r.vals[4] = v4; r.vals[5] = v5; r.vals[6] = v6; r.vals[7] = v7;
    r.exps[0] = e0; r.exps[1] = e1; r.exps[2] = e2; r.exps[3] = e3;
    return r;
  endfunction

  // Reference: pair k with its mirror, centre counted once, subtract when requested.
  function automatic longint model(input bit b7, input int k, input bit s);
    int n;
    longint a, b;
    n = b7 ? 7 : 8;
    a = b7 ? longint'(rfB[k]) : longint'(rfA[k]);
    b = b7 ? longint'(rfB[n-1-k]) : longint'(rfA[n-1-k]);
    if (k == n - 1 - k) return s ? 0 : a;
    return s ? (a - b) : (a + b);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic fill_exp(input bit b7);
    for (int k = 0; k < 4; k++) exp_v[k] = model(b7, k, sub_cur);
  endtask

  // One sequence: start, then accept outputs under a stall window [st0, st0+stlen).
  task automatic run_seq(input bit b7, input int st0, input int stlen,
                         input int xs_cyc, input bit chk_addr);
    int idx, first, cyc;
    bit prev_stall;
    logic [30:0] prev_data;
    logic [2:0]  prev_tap;
    idx = 0; first = -1; prev_stall = 0; prev_data = '0; prev_tap = '0;
    sel = b7;
`ifdef RF_PREADD_SUB_EN
    sub = sub_cur;
`endif
    ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (cyc = 1; cyc < 40 && idx < 4; cyc++) begin
      start = (cyc == xs_cyc);
      ready = !(cyc >= st0 && cyc < st0 + stlen);
      if (c_valid && first < 0) begin
        first = cyc;
        chk("first_valid_latency", first, 2);
      end
      if (prev_stall) begin
        chk("stall_data_stable", c_data, prev_data);
        chk("stall_tap_stable", c_tap, prev_tap);
        chk("stall_valid_held", c_valid, 1);
      end
      if (c_valid && !ready && chk_addr) chk("stall_addr_hold", c_addr0, 1);
      if (c_valid && ready) begin
        chk("out_data", longint'($signed(c_data)), exp_v[idx]);
        chk("out_tap", c_tap, idx);
        chk("out_last", c_last, (idx == 3));
        idx++;
      end
      prev_stall = c_valid && !ready;
      prev_data  = c_data;
      prev_tap   = c_tap;
      @(posedge clk) #1;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("output_count", idx, 4);
    chk("busy_after_last", c_busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("no_extra_output", c_valid, 0);
      @(posedge clk) #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; sel = 1'b0; sub_cur = 1'b0;
`ifdef RF_PREADD_SUB_EN
    sub = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin rfA[i] = '0; rfB[i] = '0; end

    tbl[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9);
    tbl[1] = mk(32'h1FFFFFFF, 0, 0, 0, 0, 0, 0, 32'h1FFFFFFF, 32'h3FFFFFFE, 0, 0, 0);
    tbl[2] = mk(-1, -1, -1, -1, -1, -1, -1, -1, -2, -2, -2, -2);
    tbl[3] = mk(10, -20, 30, -40, 5, 6, 7, -8, 2, -13, 36, -35);
    tbl[4] = mk(-536870912, 0, 0, 0, 0, 0, 0, -536870912, -1073741824, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_validA", validA, 0);
    chk("rst_busyA", busyA, 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_addrA0", addrA0, 0);
    chk("rst_addrA1", addrA1, 7);
    chk("rst_validB", validB, 0);
    chk("rst_addrB1", addrB1, 6);
    rst_n = 1'b1;

    // Table-driven 8-tap vectors with hand-computed sums.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) rfA[i] = 30'(tbl[t].vals[i]);
      for (int k = 0; k < 4; k++) exp_v[k] = longint'($signed(tbl[t].exps[k]));
      run_seq(1'b0, 0, 0, 0, 1'b0);
    end

    // 7-tap file: centre tap counted once.
    for (int i = 0; i < 7; i++) rfB[i] = 30'(i + 1);
    exp_v[0] = 8; exp_v[1] = 8; exp_v[2] = 8; exp_v[3] = 4;
    run_seq(1'b1, 0, 0, 0, 1'b0);

    // Back-pressure for 3 cycles right at the first valid.
    for (int i = 0; i < 8; i++) rfA[i] = 30'(i + 1);
    exp_v[0] = 9; exp_v[1] = 9; exp_v[2] = 9; exp_v[3] = 9;
    run_seq(1'b0, 2, 3, 0, 1'b1);

    // Start while busy, and start coincident with the last acceptance.
    run_seq(1'b0, 0, 0, 3, 1'b0);
    run_seq(1'b0, 0, 0, 5, 1'b0);

    // Reset mid-sequence after tap1 is accepted.
    sel = 1'b0;
    @(posedge clk) #1; start = 1'b1;
    @(posedge clk) #1; start = 1'b0;
    @(posedge clk) #1;
    chk("pre_rst_tap0", validA && tapA == 0, 1);
    @(posedge clk) #1;
    chk("pre_rst_tap1", validA && tapA == 1, 1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    chk("midrst_valid", validA, 0);
    chk("midrst_busy", busyA, 0);
    chk("midrst_addr0", addrA0, 0);
    chk("midrst_addr1", addrA1, 7);
    repeat (3) begin
      @(posedge clk) #1;
      chk("midrst_quiet", validA, 0);
    end
    run_seq(1'b0, 0, 0, 0, 1'b0);

`ifdef RF_PREADD_SUB_EN
    sub_cur = 1'b1;
    for (int i = 0; i < 8; i++) rfA[i] = 30'(i + 1);
    exp_v[0] = -7; exp_v[1] = -5; exp_v[2] = -3; exp_v[3] = -1;
    run_seq(1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 7; i++) rfB[i] = 30'(i + 1);
    fill_exp(1'b1);
    chk("sub_centre_model", exp_v[3], 0);
    run_seq(1'b1, 0, 0, 0, 1'b0);
    sub_cur = 1'b0;
`endif

    // Randomised contents, size, stalls and (when present) sub.
    for (int r = 0; r < 20; r++) begin
      bit b7;
      b7 = 1'($urandom_range(0, 1));
`ifdef RF_PREADD_SUB_EN
      sub_cur = 1'($urandom_range(0, 1));
`endif
      for (int i = 0; i < 8; i++) begin
        rfA[i] = 30'($urandom);
        rfB[i] = 30'($urandom);
      end
      fill_exp(b7);
      run_seq(b7, $urandom_range(1, 5), $urandom_range(0, 3), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_symm_preadd_seq.md
Name: rf_symm_preadd_seq

Overview:
- Downstream consumer of the 8-deep, 30-bit, 2-read shift register file in the PIRDSP datapath.
- After each new sample is shifted into the register file, the block sequences both read ports over symmetric tap pairs (k, RF_SIZE-1-k).
- It pre-adds each pair and streams the sums to the multiplier stage over a valid/ready handshake.
- It also drives a busy flag that upstream logic uses to gate the register-file write_enable while a sequence is in flight.

Parameters:
- DATA_W, 30: register-file word width; signed two's complement.
- RF_SIZE, 8: register-file depth; any value >= 2, odd allowed.
- ADDR_W, $clog2(RF_SIZE): read-address width.
- SUM_W, DATA_W+1: pre-adder output width; full precision, no overflow.
- N_OUT, (RF_SIZE+1)/2: outputs per sequence.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: pulse meaning a new sample was shifted in; begin a sequence.
- busy, output, 1: sequence in progress or output pending; upstream must hold write_enable low while busy=1.
- rf_addr_0, output, ADDR_W: read address to register-file port 0.
- rf_addr_1, output, ADDR_W: read address to register-file port 1.
- rf_data_0, input, DATA_W: combinational read data from port 0.
- rf_data_1, input, DATA_W: combinational read data from port 1.
- out_data, output, SUM_W: registered pre-add result.
- out_tap, output, ADDR_W: tap index k of out_data.
- out_last, output, 1: out_data is the final pair of the sequence.
- out_valid, output, 1: out_data, out_tap and out_last are valid.
- out_ready, input, 1: consumer accepts the output when out_valid=1.

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of current state:
  - state=IDLE, k=0.
  - out_valid=0, out_data=0, out_tap=0, out_last=0, busy=0.
  - rf_addr_0=0, rf_addr_1=RF_SIZE-1.
  - Any in-flight sequence is abandoned and no further outputs are produced.
- States: IDLE and RUN. busy = (state==RUN) | out_valid.
- IDLE:
  - rf_addr_0=0, rf_addr_1=RF_SIZE-1.
  - start=1 with busy=0: go to RUN with k=0.
  - start=1 with busy=1 is ignored; no queuing.
- RUN:
  - rf_addr_0=k, rf_addr_1=RF_SIZE-1-k (combinational from k).
  - capture = ~out_valid | out_ready.
  - On capture:
    - out_data <= sext(rf_data_0) + sext(rf_data_1).
    - out_tap <= k.
    - out_last <= (k==N_OUT-1).
    - out_valid <= 1.
    - k <= k+1.
    - If k==N_OUT-1, go to IDLE with k=0.
  - No capture (output stalled): k holds and the addresses hold.
- Odd RF_SIZE:
  - The centre tap k=(RF_SIZE-1)/2 has rf_addr_0 == rf_addr_1.
  - For that tap, rf_data_1 is treated as 0, so out_data = sext(rf_data_0).
- Handshake:
  - Acceptance happens when out_valid & out_ready. With no new capture in that cycle, out_valid <= 0.
  - While out_valid=1 and out_ready=0, all output fields are stable.
- Timing:
  - start in cycle T: first out_valid=1 in cycle T+2.
  - With out_ready held high: one output per cycle, and busy drops the cycle after the last acceptance.
- Simultaneous events: a start in the same cycle as the last acceptance is ignored, because busy=1 in that cycle.

Optional Feature:
- Macro: RF_PREADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on an accepted start and held for the whole sequence.
  - sub=1 computes sext(rf_data_0) - sext(rf_data_1) for antisymmetric filters.
  - The odd-RF_SIZE centre tap output is then 0.
- Undefined: the port is absent and the block always adds.

Decomposition:
- Package rf_preadd_pkg holds:
  - the state enum (IDLE, RUN);
  - a helper function computing N_OUT from RF_SIZE;
  - the default DATA_W and RF_SIZE constants.
- One natural sub-module: rf_preadd_out_reg, the single-entry output register with the valid/ready logic.

Test Plan:
- RF contents 1..8 (addr0=1 ... addr7=8), start, out_ready=1:
  - outputs (tap0,9), (1,9), (2,9), (3,9,last) in cycles T+2..T+5;
  - busy=0 at T+6.
- Contents 0x1FFFFFFF at addrs 0 and 7: tap0 out_data=0x3FFFFFFE in 31 bits, no overflow. Contents -1 and -1: out_data=-2 (0x7FFFFFFE).
- out_ready=0 for 3 cycles after the first valid: out_data and out_tap stay constant, rf_addr_0 holds 1, no output lost or duplicated.
- RF_SIZE=7, contents 1..7: outputs 8, 8, 8, 4 (centre tap); out_last on tap 3.
- start pulsed while busy: ignored, exactly 4 outputs. rst_n=0 mid-sequence after tap1: out_valid=0 and busy=0 next cycle, then a fresh start restarts at tap0.
- RF_PREADD_SUB_EN with sub=1, contents 1..8: outputs -7, -5, -3, -1.
